// File: rtl/bidi_message_queue_arb.sv
// Two-requester round-robin arbiter in front of a single-port word memory, 1-cycle read latency.
// Define BIDI_MESSAGE_QUEUE_ARB_LOCK_EN to add mN_lock ports and the LOCK0/LOCK1 bus-hold states.
module bidi_message_queue_arb #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [31:0]          m0_wdata,
`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
  input  logic                 m0_lock,
`endif
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [31:0]          m1_wdata,
`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
  input  logic                 m1_lock,
`endif
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [31:0]          m1_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [31:0]          mem_write_data,
  input  logic [31:0]          mem_read_data,
  output logic [1:0]           owner
);

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   rvalid0_q, rvalid0_d;
  logic   rvalid1_q, rvalid1_d;
  logic   gnt0, gnt1;
  logic   lock0, lock1;

`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
  assign lock0 = m0_lock;
  assign lock1 = m1_lock;
`else
  // Without the lock feature the state machine can never leave ARB.
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    prio_d  = prio_q;

    unique case (state_q)
      ARB: begin
        if (m0_req && (!m1_req || !prio_q)) gnt0 = 1'b1;
        else if (m1_req)                    gnt1 = 1'b1;
      end
      LOCK0:   gnt0 = m0_req;
      LOCK1:   gnt1 = m1_req;
      default: ;
    endcase

    // Outputs are forced low for the whole time reset is held, not just after a clock edge.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    // A grant always hands priority to the other side; the lock bit of that access picks the next state.
    if (gnt0) begin
      prio_d  = 1'b1;
      state_d = lock0 ? LOCK0 : ARB;
    end
    if (gnt1) begin
      prio_d  = 1'b0;
      state_d = lock1 ? LOCK1 : ARB;
    end

    rvalid0_d = gnt0 && !m0_we;
    rvalid1_d = gnt1 && !m1_we;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    mem_addr       = '0;
    mem_write_data = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    if (gnt0) begin
      mem_addr       = m0_addr;
      mem_write_data = m0_wdata;
      mem_write_en   = m0_we;
      mem_read_en    = !m0_we;
    end else if (gnt1) begin
      mem_addr       = m1_addr;
      mem_write_data = m1_wdata;
      mem_write_en   = m1_we;
      mem_read_en    = !m1_we;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rvalid0_q ? mem_read_data : 32'h0;
  assign m1_rdata  = rvalid1_q ? mem_read_data : 32'h0;
  assign owner     = state_q;

endmodule

// File: tb/tb_bidi_message_queue_arb.sv
// Self-checking bench for bidi_message_queue_arb: directed scenarios plus a randomized run
// checked against a transaction-level arbiter/memory model.
module tb_bidi_message_queue_arb;
  localparam int AW = 12;
`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en, mem_write_en;
  logic [31:0]   mem_write_data, mem_read_data;
  logic [1:0]    owner;

  int vectors = 0;
  int miscompares = 0;

  // Environment memory: synchronous write, registered read.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_data;
    rd_q <= mem[mem_addr];
  end
  assign mem_read_data = rd_q;

  bidi_message_queue_arb #(.ADDR_BITS(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
    .m0_lock(m0_lock),
`endif
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .owner(owner)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_req = 1; m0_we = 0; m0_addr = 12'h010; m0_wdata = 32'h1111_1111; m0_lock = 1;
    m1_req = 1; m1_we = 1; m1_addr = 12'h020; m1_wdata = 32'h2222_2222; m1_lock = 1;
    for (int i = 0; i < 2; i++) begin
      #3;
      vectors++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read_en, mem_write_en} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl[%0d] got %b want 000000", i,
                 {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read_en, mem_write_en});
      end
      vectors++;
      if ({m0_rdata, m1_rdata, mem_write_data, mem_addr, owner} !== '0) begin
        miscompares++;
        $display("FAIL reset_data[%0d] got rd0=%h rd1=%h wd=%h addr=%h owner=%b want all 0",
                 i, m0_rdata, m1_rdata, mem_write_data, mem_addr, owner);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    mem[12'h401] = 32'hDEAD_BEEF;
    m0_req = 1; m0_we = 0; m0_addr = 12'h401;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt, mem_read_en, mem_write_en} !== 4'b1010 || mem_addr !== 12'h401) begin
      miscompares++;
      $display("FAIL read_grant got gnt0/gnt1/re/we=%b addr=%h want 1010 addr=401",
               {m0_gnt, m1_gnt, mem_read_en, mem_write_en}, mem_addr);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_data got rvalid=%b rdata=%h want 1 deadbeef", m0_rvalid, m0_rdata);
    end
    vectors++;
    if ({m1_gnt, m1_rvalid, m1_rdata} !== '0) begin
      miscompares++;
      $display("FAIL read_m1_quiet got gnt=%b rvalid=%b rdata=%h want 0 0 0", m1_gnt, m1_rvalid, m1_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_alternate();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 12'h100; m0_wdata = 32'hA0;
    m1_req = 1; m1_we = 1; m1_addr = 12'h200; m1_wdata = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL alternate[%0d] got gnt0/gnt1=%b want %b", i, {m0_gnt, m1_gnt},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_write();
    m1_req = 1; m1_we = 1; m1_addr = 12'h001; m1_wdata = 32'h5;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt, mem_read_en, mem_write_en} !== 4'b0101 ||
        mem_addr !== 12'h001 || mem_write_data !== 32'h5) begin
      miscompares++;
      $display("FAIL write_issue got gnt/re/we=%b addr=%h data=%h want 0101 001 00000005",
               {m0_gnt, m1_gnt, mem_read_en, mem_write_en}, mem_addr, mem_write_data);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || mem[12'h001] !== 32'h5) begin
      miscompares++;
      $display("FAIL write_after got rvalid=%b rdata=%h mem=%h want 0 0 5", m1_rvalid, m1_rdata, mem[12'h001]);
    end
    @(negedge clk);
  endtask

`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 12'h000; m0_lock = 1;
    m1_req = 1; m1_we = 1; m1_addr = 12'h002; m1_wdata = 32'h9;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || owner !== 2'b00) begin
      miscompares++;
      $display("FAIL lock_take got gnt=%b owner=%b want 10 00", {m0_gnt, m1_gnt}, owner);
    end
    @(negedge clk);
    m0_req = 0; m0_lock = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (m1_gnt !== 1'b0 || owner !== 2'b01 || m0_rvalid !== (i == 0)) begin
        miscompares++;
        $display("FAIL lock_hold[%0d] got gnt1=%b owner=%b rvalid0=%b want 0 01 %0d",
                 i, m1_gnt, owner, m0_rvalid, i == 0);
      end
      @(negedge clk);
    end
    m0_req = 1; m0_we = 1; m0_addr = 12'h000; m0_wdata = 32'h7; m0_lock = 0;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b101 || mem_write_data !== 32'h7 || owner !== 2'b01) begin
      miscompares++;
      $display("FAIL lock_release got gnt/we=%b data=%h owner=%b want 101 7 01",
               {m0_gnt, m1_gnt, mem_write_en}, mem_write_data, owner);
    end
    @(negedge clk);
    m0_req = 0;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt} !== 2'b01 || owner !== 2'b00) begin
      miscompares++;
      $display("FAIL lock_after got gnt=%b owner=%b want 01 00", {m0_gnt, m1_gnt}, owner);
    end
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  task automatic test_reset_midread();
    // m1 takes the bus (locked when available), then reads again; reset lands in the rvalid cycle.
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 12'h003; m1_lock = LOCK_EN;
    #1;
    vectors++;
    if (m1_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_first got gnt1=%b want 1", m1_gnt);
    end
    @(negedge clk);
    m1_addr = 12'h004;
    #1;
    vectors++;
    if (m1_gnt !== 1'b1 || owner !== (LOCK_EN ? 2'b10 : 2'b00)) begin
      miscompares++;
      $display("FAIL midrst_second got gnt1=%b owner=%b want 1 %b", m1_gnt, owner, LOCK_EN ? 2'b10 : 2'b00);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    #1;
    vectors++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || owner !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_discard got rvalid1=%b rdata1=%h owner=%b want 0 0 00", m1_rvalid, m1_rdata, owner);
    end
    #2 rst_n = 1;
    @(negedge clk);
    m0_req = 1; m1_req = 1; m0_addr = 12'h005; m1_addr = 12'h006;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || m1_rvalid !== 1'b0 || owner !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_rearb got gnt=%b rvalid1=%b owner=%b want 10 0 00", {m0_gnt, m1_gnt}, m1_rvalid, owner);
    end
    @(negedge clk);
    // m0 read leaves prio at 1; reset must bring it back to 0.
    idle_inputs();
    m0_req = 1; m0_addr = 12'h007;
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    #1;
    vectors++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_m0 got rvalid0=%b rdata0=%h want 0 0", m0_rvalid, m0_rdata);
    end
    #2 rst_n = 1;
    @(negedge clk);
    m0_req = 1; m1_req = 1;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL midrst_prio got gnt=%b want 10", {m0_gnt, m1_gnt});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    logic          r_req [2], r_we [2], r_lk [2], pend [2], rv_m [2];
    logic [AW-1:0] r_addr [2];
    logic [31:0]   r_wd [2], rd_m [2];
    logic [31:0]   ref_mem [16];
    int            prio_m, st_m, g;
    logic [3:0]    e_ctl;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h0;
      mem[12'h800 + i] = 32'h0;
    end
    for (int n = 0; n < 2; n++) begin
      pend[n] = 0; rv_m[n] = 0; rd_m[n] = '0; r_req[n] = 0; r_we[n] = 0; r_lk[n] = 0;
      r_addr[n] = '0; r_wd[n] = '0;
    end
    prio_m = 0; st_m = 0;
    do_reset();

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          r_req[n]  = ($urandom_range(3) != 0);
          r_we[n]   = $urandom_range(1) == 1;
          r_addr[n] = AW'(12'h800 + $urandom_range(15));
          r_wd[n]   = $urandom;
          r_lk[n]   = LOCK_EN && ($urandom_range(5) == 0);
          pend[n]   = r_req[n];
        end
      end
      m0_req = r_req[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_wd[0]; m0_lock = r_lk[0];
      m1_req = r_req[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_wd[1]; m1_lock = r_lk[1];
      #1;

      if (st_m == 1)                g = r_req[0] ? 0 : -1;
      else if (st_m == 2)           g = r_req[1] ? 1 : -1;
      else if (r_req[0] && r_req[1]) g = prio_m;
      else if (r_req[0])            g = 0;
      else if (r_req[1])            g = 1;
      else                          g = -1;

      e_ctl  = {g == 0, g == 1, g >= 0 && !r_we[g >= 0 ? g : 0], g >= 0 && r_we[g >= 0 ? g : 0]};
      e_addr = (g >= 0) ? r_addr[g] : '0;
      e_wd   = (g >= 0) ? r_wd[g] : '0;

      vectors++;
      if ({m0_gnt, m1_gnt, mem_read_en, mem_write_en} !== e_ctl) begin
        miscompares++;
        $display("FAIL rnd_ctl[%0d] got gnt/re/we=%b want %b", cyc, {m0_gnt, m1_gnt, mem_read_en, mem_write_en}, e_ctl);
      end
      vectors++;
      if (mem_addr !== e_addr || mem_write_data !== e_wd) begin
        miscompares++;
        $display("FAIL rnd_bus[%0d] got addr=%h wd=%h want %h %h", cyc, mem_addr, mem_write_data, e_addr, e_wd);
      end
      vectors++;
      if (m0_rvalid !== rv_m[0] || m1_rvalid !== rv_m[1] ||
          m0_rdata !== (rv_m[0] ? rd_m[0] : 32'h0) || m1_rdata !== (rv_m[1] ? rd_m[1] : 32'h0)) begin
        miscompares++;
        $display("FAIL rnd_read[%0d] got rv=%b%b rd0=%h rd1=%h want rv=%b%b rd0=%h rd1=%h", cyc,
                 m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, rv_m[0], rv_m[1],
                 rv_m[0] ? rd_m[0] : 32'h0, rv_m[1] ? rd_m[1] : 32'h0);
      end
      vectors++;
      if (owner !== 2'(st_m)) begin
        miscompares++;
        $display("FAIL rnd_owner[%0d] got %b want %b", cyc, owner, 2'(st_m));
      end

      rv_m[0] = 0; rv_m[1] = 0;
      if (g >= 0) begin
        if (r_we[g]) ref_mem[r_addr[g][3:0]] = r_wd[g];
        else begin
          rv_m[g] = 1;
          rd_m[g] = ref_mem[r_addr[g][3:0]];
        end
        pend[g] = 0;
        if (st_m == 0 || !r_lk[g]) prio_m = 1 - g;
        st_m = r_lk[g] ? g + 1 : 0;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_write();
`ifdef BIDI_MESSAGE_QUEUE_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_midread();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
